// File: rtl/intf_slave_rx.sv
// Slave-side receive stage for the intf bundle: buffers the master's word
// stream in a first-word fall-through FIFO, delimits packets, reports packet
// length and truncates packets longer than MAX_LEN words.
module intf_slave_rx #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c,
    input  logic             d,
    input  logic [11:0]      e,
    output logic             a,
    output logic             b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [11:0]      m_data,
    output logic             m_last,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pkt_len_valid,
    output logic [7:0]       err_cnt
);

    localparam int unsigned      AW     = $clog2(DEPTH);
    localparam logic [AW:0]      Full   = (AW + 1)'(DEPTH);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

    state_e           state_q, state_d;
    logic [12:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [LEN_W-1:0] wc_q, wc_d, wc_inc;
    logic [LEN_W-1:0] pkt_len_q;
    logic             pkt_len_valid_q;
    logic             a_q, a_d;
    logic             b_q;
    logic [7:0]       err_cnt_q;
    logic             accept, push, pop, trunc, close;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake decode, packet delimiting, next state, FIFO fill and ready
    always_comb begin
        accept  = c & a_q;
        push    = accept & (state_q != StDrop);
        pop     = m_valid & m_ready;
        wc_inc  = wc_q + LEN_W'(1);
        // Word number MAX_LEN without d closes the stored packet early
        trunc   = push & ~d & (wc_inc == MaxLen);
        close   = push & (d | trunc);
        state_d = state_q;
        wc_d    = wc_q;
        count_d = count_q;

        if (push) begin
            wc_d = close ? '0 : wc_inc;
        end

        case (state_q)
            StIdle, StRecv: begin
                if (push) begin
                    if (d) begin
                        state_d = StIdle;
                    end else if (trunc) begin
                        state_d = StDrop;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            StDrop: begin
                if (accept && d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        // Discarded words never occupy the FIFO, so DROP can always accept
        a_d = (state_d == StDrop) || (count_d != Full);
    end

    // FIFO storage; entries are {last, data}
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {d | trunc, e};
        end
    end

    // FIFO pointers, fill count and registered ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            a_q     <= a_d;
        end
    end

    // Word count, packet length report, truncation strobe and error counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wc_q            <= '0;
            pkt_len_q       <= '0;
            pkt_len_valid_q <= 1'b0;
            b_q             <= 1'b0;
            err_cnt_q       <= '0;
        end else begin
            wc_q            <= wc_d;
            pkt_len_valid_q <= close;
            b_q             <= trunc;
            if (close) begin
                pkt_len_q <= wc_inc;
            end
            if (trunc && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign a             = a_q;
    assign b             = b_q;
    assign m_valid       = (count_q != '0);
    // Gated so the outputs read zero while the FIFO is empty and after reset
    assign m_data        = m_valid ? mem[rd_ptr_q][11:0] : 12'h000;
    assign m_last        = m_valid ? mem[rd_ptr_q][12] : 1'b0;
    assign pkt_len       = pkt_len_q;
    assign pkt_len_valid = pkt_len_valid_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_intf_slave_rx.sv
// Directed self-checking bench for intf_slave_rx (DEPTH=16, MAX_LEN=64).
module tb_intf_slave_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c, d;
    logic [11:0] e;
    logic        a, b;
    logic        m_valid, m_ready;
    logic [11:0] m_data;
    logic        m_last;
    logic [6:0]  pkt_len;
    logic        pkt_len_valid;
    logic [7:0]  err_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [12:0] q_out[$];
    int          n_plv;
    int          n_b;
    int          last_len;

    intf_slave_rx #(
        .DEPTH  (16),
        .MAX_LEN(64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .c            (c),
        .d            (d),
        .e            (e),
        .a            (a),
        .b            (b),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .pkt_len      (pkt_len),
        .pkt_len_valid(pkt_len_valid),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Observe the downstream stream and report pulses away from the rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) q_out.push_back({m_last, m_data});
            if (pkt_len_valid) begin
                n_plv++;
                last_len = int'(pkt_len);
            end
            if (b) n_b++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qword(input int i);
        return (i < q_out.size()) ? int'(q_out[i]) : -1;
    endfunction

    task automatic clear_obs();
        q_out.delete();
        n_plv    = 0;
        n_b      = 0;
        last_len = -1;
    endtask

    // Offer one word and hold it until the slave accepts it
    task automatic send(input logic last, input logic [11:0] data);
        int   n;
        logic acc;
        c   = 1'b1;
        d   = last;
        e   = data;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = a;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", int'(acc), 1);
        c = 1'b0;
        d = 1'b0;
    endtask

    // Let the FIFO empty (caller holds m_ready high), then settle pulses
    task automatic drain();
        int n;
        n = 0;
        while (m_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (m_valid) check("drain_timeout", int'(m_valid), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        c       = 1'b1;
        d       = 1'b0;
        e       = 12'h0AB;
        m_ready = 1'b0;
        clear_obs();

        // 1: reset with the master already offering a word
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a", int'(a), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_plv", int'(pkt_len_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c     = 1'b0;
        e     = 12'h000;
        @(posedge clk);
        @(negedge clk);
        check("rel_a", int'(a), 1);
        check("rel_m_valid", int'(m_valid), 0);
        check("rel_pkt_len", int'(pkt_len), 0);
        check("rel_err_cnt", int'(err_cnt), 0);
        check("rel_b", int'(b), 0);
        @(posedge clk);
        #1;

        // 2: three-word packet straight through
        clear_obs();
        m_ready = 1'b1;
        send(1'b0, 12'h001);
        send(1'b0, 12'h002);
        send(1'b1, 12'h003);
        drain();
        check("p3_count", q_out.size(), 3);
        check("p3_w0", qword(0), 'h0001);
        check("p3_w1", qword(1), 'h0002);
        check("p3_w2", qword(2), 'h1003);
        check("p3_len", last_len, 3);
        check("p3_plv_pulses", n_plv, 1);
        check("p3_b", n_b, 0);

        // 3: fill the FIFO, master holds the 17th word until space frees up
        clear_obs();
        m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) send(1'b0, 12'(i));
        @(negedge clk);
        check("full_a", int'(a), 0);
        check("full_m_valid", int'(m_valid), 1);
        c = 1'b1;
        d = 1'b1;
        e = 12'h011;
        repeat (2) @(negedge clk);
        check("held_a", int'(a), 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        check("a_rise", int'(a), 1);
        @(posedge clk);
        #1;
        c = 1'b0;
        d = 1'b0;
        @(negedge clk);
        check("refull_a", int'(a), 0);
        m_ready = 1'b1;
        drain();
        check("f17_count", q_out.size(), 17);
        check("f17_w0", qword(0), 'h0001);
        check("f17_w15", qword(15), 'h0010);
        check("f17_w16", qword(16), 'h1011);
        check("f17_len", last_len, 17);

        // 4: 66-word packet truncated at 64
        clear_obs();
        m_ready = 1'b1;
        for (int i = 1; i <= 66; i++) send(i == 66, 12'(i));
        drain();
        check("tr_count", q_out.size(), 64);
        check("tr_w0", qword(0), 'h0001);
        check("tr_w62", qword(62), 'h003F);
        check("tr_w63", qword(63), 'h1040);
        check("tr_b_pulses", n_b, 1);
        check("tr_plv_pulses", n_plv, 1);
        check("tr_len", last_len, 64);
        check("tr_err_cnt", int'(err_cnt), 1);
        check("tr_a_after", int'(a), 1);

        // 5: hold 8 entries while pushing and popping together for 10 cycles
        clear_obs();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 12'h100 + 12'(i));
        m_ready = 1'b1;
        for (int i = 8; i < 18; i++) send(i == 17, 12'h100 + 12'(i));
        m_ready = 1'b0;
        @(negedge clk);
        check("pp_popped", q_out.size(), 10);
        check("pp_a", int'(a), 1);
        check("pp_w0", qword(0), 'h0100);
        check("pp_w9", qword(9), 'h0109);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();
        check("pp_total", q_out.size(), 18);
        check("pp_w10", qword(10), 'h010A);
        check("pp_w17", qword(17), 'h1111);
        check("pp_len", last_len, 18);

        // 6: one-cycle reset in the middle of a packet
        clear_obs();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(1'b0, 12'h200 + 12'(i));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_m_valid", int'(m_valid), 0);
        check("mr_err_cnt", int'(err_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        check("mr_a", int'(a), 1);
        @(posedge clk);
        #1;
        clear_obs();
        m_ready = 1'b1;
        send(1'b0, 12'h2A1);
        send(1'b1, 12'h2A2);
        drain();
        check("mr_count", q_out.size(), 2);
        check("mr_w0", qword(0), 'h02A1);
        check("mr_w1", qword(1), 'h12A2);
        check("mr_len", last_len, 2);
        check("mr_b", n_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
